// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of the single data_memory port.
// Port 0 is the core load/store path, port 1 the image loader, which may
// hold a bounded burst lock. Read data returns one cycle after a read grant.
module dmem_arbiter #(
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned ADDRESS_WIDTH = 20,
  parameter int unsigned MAX_BURST     = 16,
  parameter int unsigned CNT_WIDTH     = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     p0_req,
  input  logic                     p0_we,
  input  logic                     p0_be,
  input  logic [ADDRESS_WIDTH-1:0] p0_addr,
  input  logic [DATA_WIDTH-1:0]    p0_wdata,
  output logic                     p0_gnt,
  output logic                     p0_rvalid,
  output logic [DATA_WIDTH-1:0]    p0_rdata,
  output logic                     core_stall,
  input  logic                     p1_req,
  input  logic                     p1_we,
  input  logic                     p1_be,
  input  logic [ADDRESS_WIDTH-1:0] p1_addr,
  input  logic [DATA_WIDTH-1:0]    p1_wdata,
  input  logic                     p1_lock,
  output logic                     p1_gnt,
  output logic                     p1_rvalid,
  output logic [DATA_WIDTH-1:0]    p1_rdata,
  output logic [ADDRESS_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0]    mem_wdata,
  output logic                     mem_we,
  output logic                     mem_re,
  output logic                     mem_be,
  input  logic [DATA_WIDTH-1:0]    mem_rdata,
  output logic [CNT_WIDTH-1:0]     p0_wait_cnt
);

  localparam int unsigned BW = $clog2(MAX_BURST + 1);
  localparam logic [BW-1:0] MAX_B = BW'(MAX_BURST);

  typedef enum logic {
    IDLE  = 1'b0,
    LOCK1 = 1'b1
  } state_t;

  state_t               state_q, state_d;
  logic [BW-1:0]        burst_q, burst_d;
  logic                 last_q, last_d;   // port granted most recently
  logic                 pend_q, pend_d;   // read issued last cycle
  logic                 owner_q, owner_d; // port that issued that read
  logic [CNT_WIDTH-1:0] wait_q, wait_d;
  logic                 gnt0, gnt1;

  // State registers; reset drops any in-flight read return
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      burst_q <= '0;
      last_q  <= 1'b1;
      pend_q  <= 1'b0;
      owner_q <= 1'b0;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      burst_q <= burst_d;
      last_q  <= last_d;
      pend_q  <= pend_d;
      owner_q <= owner_d;
      wait_q  <= wait_d;
    end
  end

  // Arbitration, burst lock tracking, read tracker and stall counter
  always_comb begin
    state_d = state_q;
    burst_d = burst_q;
    last_d  = last_q;
    gnt0    = 1'b0;
    gnt1    = 1'b0;
    case (state_q)
      IDLE: begin
        if (p0_req && (!p1_req || last_q)) begin
          gnt0 = 1'b1;
        end else if (p1_req) begin
          gnt1 = 1'b1;
          if (p1_lock) begin
            state_d = LOCK1;
            burst_d = BW'(1);
          end
        end
      end
      LOCK1: begin
        if (!p1_lock) begin
          state_d = IDLE;
          burst_d = '0;
        end else if (burst_q == MAX_B) begin
          // Burst exhausted: hand the next conflict to the core
          state_d = IDLE;
          burst_d = '0;
          last_d  = 1'b1;
        end else if (p1_req) begin
          gnt1    = 1'b1;
          burst_d = burst_q + BW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    if (!rst) begin
      gnt0 = 1'b0;
      gnt1 = 1'b0;
    end
    if (gnt0) begin
      last_d = 1'b0;
    end else if (gnt1) begin
      last_d = 1'b1;
    end
    pend_d  = (gnt0 & ~p0_we) | (gnt1 & ~p1_we);
    owner_d = gnt1;
    wait_d  = wait_q;
    if (core_stall && (wait_q != '1)) begin
      wait_d = wait_q + CNT_WIDTH'(1);
    end
  end

  assign p0_gnt      = gnt0;
  assign p1_gnt      = gnt1;
  assign core_stall  = p0_req & ~gnt0;
  assign p0_wait_cnt = wait_q;

  // Memory port mux driven by the granted requester
  assign mem_addr  = gnt0 ? p0_addr  : (gnt1 ? p1_addr  : '0);
  assign mem_wdata = gnt0 ? p0_wdata : (gnt1 ? p1_wdata : '0);
  assign mem_be    = (gnt0 & p0_be) | (gnt1 & p1_be);
  assign mem_we    = (gnt0 & p0_we) | (gnt1 & p1_we);
  assign mem_re    = (gnt0 & ~p0_we) | (gnt1 & ~p1_we);

  // Read return routed by the registered owner
  assign p0_rvalid = pend_q & ~owner_q;
  assign p1_rvalid = pend_q & owner_q;
  assign p0_rdata  = p0_rvalid ? mem_rdata : '0;
  assign p1_rdata  = p1_rvalid ? mem_rdata : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: one task per scenario, inline checks.
module tb_dmem_arbiter;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 20;
  localparam int unsigned MB = 16;
  localparam int unsigned CW = 6;

  logic          clk = 1'b0;
  logic          rst;
  logic          p0_req, p0_we, p0_be, p0_gnt, p0_rvalid, core_stall;
  logic [AW-1:0] p0_addr;
  logic [DW-1:0] p0_wdata, p0_rdata;
  logic          p1_req, p1_we, p1_be, p1_lock, p1_gnt, p1_rvalid;
  logic [AW-1:0] p1_addr;
  logic [DW-1:0] p1_wdata, p1_rdata;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic          mem_we, mem_re, mem_be;
  logic [CW-1:0] p0_wait_cnt;

  int errors = 0;
  int checks = 0;

  dmem_arbiter #(
    .DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .MAX_BURST(MB), .CNT_WIDTH(CW)
  ) dut (
    .clk(clk), .rst(rst),
    .p0_req(p0_req), .p0_we(p0_we), .p0_be(p0_be), .p0_addr(p0_addr),
    .p0_wdata(p0_wdata), .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid),
    .p0_rdata(p0_rdata), .core_stall(core_stall),
    .p1_req(p1_req), .p1_we(p1_we), .p1_be(p1_be), .p1_addr(p1_addr),
    .p1_wdata(p1_wdata), .p1_lock(p1_lock), .p1_gnt(p1_gnt),
    .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
    .mem_re(mem_re), .mem_be(mem_be), .mem_rdata(mem_rdata),
    .p0_wait_cnt(p0_wait_cnt)
  );

  always #5 clk = ~clk;

  task automatic clear_inputs();
    p0_req = 1'b0; p0_we = 1'b0; p0_be = 1'b0; p0_addr = '0; p0_wdata = '0;
    p1_req = 1'b0; p1_we = 1'b0; p1_be = 1'b0; p1_addr = '0; p1_wdata = '0;
    p1_lock = 1'b0; mem_rdata = '0;
  endtask

  // Advance to just after the next rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    clear_inputs();
    step();
    step();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    clear_inputs();
    p0_req = 1'b1; p1_req = 1'b1; p0_addr = 20'h00123; mem_rdata = 32'h1234_5678;
    step();
    @(negedge clk);
    checks++;
    if ({p0_gnt, p1_gnt, mem_we, mem_re, p0_rvalid, p1_rvalid} !== 6'b0) begin
      errors++;
      $display("FAIL reset_strobes: got %b expected 000000",
               {p0_gnt, p1_gnt, mem_we, mem_re, p0_rvalid, p1_rvalid});
    end
    checks++;
    if ({p0_rdata, p1_rdata} !== 64'h0) begin
      errors++;
      $display("FAIL reset_rdata: got %h expected 0", {p0_rdata, p1_rdata});
    end
    checks++;
    if (mem_addr !== 20'h0) begin
      errors++;
      $display("FAIL reset_addr: got %h expected 0", mem_addr);
    end
    checks++;
    if (p0_wait_cnt !== 6'd0) begin
      errors++;
      $display("FAIL reset_wait_cnt: got %0d expected 0", p0_wait_cnt);
    end
    step();
    clear_inputs();
    rst = 1'b1;
  endtask

  task automatic test_p0_read();
    do_reset();
    p0_req = 1'b1; p0_addr = 20'h00010;
    @(negedge clk);
    checks++;
    if ({p0_gnt, p1_gnt, mem_re, mem_we, core_stall} !== 5'b10100) begin
      errors++;
      $display("FAIL p0_read_grant: got %b expected 10100",
               {p0_gnt, p1_gnt, mem_re, mem_we, core_stall});
    end
    checks++;
    if (mem_addr !== 20'h00010) begin
      errors++;
      $display("FAIL p0_read_addr: got %h expected 00010", mem_addr);
    end
    step();
    clear_inputs();
    mem_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    checks++;
    if ({p0_rvalid, p1_rvalid} !== 2'b10 || p0_rdata !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL p0_read_return: got rv=%b data=%h expected rv=10 data=deadbeef",
               {p0_rvalid, p1_rvalid}, p0_rdata);
    end
    checks++;
    if (p1_rdata !== 32'h0) begin
      errors++;
      $display("FAIL p0_read_p1_rdata: got %h expected 0", p1_rdata);
    end
    step();
    @(negedge clk);
    checks++;
    if (p0_rvalid !== 1'b0 || p0_rdata !== 32'h0) begin
      errors++;
      $display("FAIL p0_read_single_pulse: got rv=%b data=%h expected rv=0 data=0",
               p0_rvalid, p0_rdata);
    end
    clear_inputs();
  endtask

  task automatic test_alternate();
    logic [2:0] exp;
    logic [AW-1:0] exp_addr;
    do_reset();
    p0_req = 1'b1; p0_we = 1'b1; p0_addr = 20'h00100; p0_wdata = 32'h1111_0000;
    p1_req = 1'b1; p1_we = 1'b1; p1_addr = 20'h00200; p1_wdata = 32'h2222_0000;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      exp = (i % 2 == 0) ? 3'b100 : 3'b011;
      exp_addr = (i % 2 == 0) ? 20'h00100 : 20'h00200;
      checks++;
      if ({p0_gnt, p1_gnt, core_stall} !== exp) begin
        errors++;
        $display("FAIL alternate_cycle%0d: got gnt0/gnt1/stall=%b expected %b",
                 i, {p0_gnt, p1_gnt, core_stall}, exp);
      end
      checks++;
      if (mem_addr !== exp_addr || mem_we !== 1'b1) begin
        errors++;
        $display("FAIL alternate_mux%0d: got addr=%h we=%b expected addr=%h we=1",
                 i, mem_addr, mem_we, exp_addr);
      end
      step();
    end
    clear_inputs();
    @(negedge clk);
    checks++;
    if (p0_wait_cnt !== 6'd2) begin
      errors++;
      $display("FAIL alternate_wait_cnt: got %0d expected 2", p0_wait_cnt);
    end
  endtask

  task automatic test_burst();
    logic [2:0] exp;
    do_reset();
    p0_req = 1'b1; p0_we = 1'b1; p0_addr = 20'h00300;
    p1_req = 1'b1; p1_we = 1'b1; p1_addr = 20'h00400; p1_lock = 1'b1;
    for (int i = 0; i < 19; i++) begin
      @(negedge clk);
      if (i == 0 || i == 18)      exp = 3'b100;
      else if (i <= 16)           exp = 3'b011;
      else                        exp = 3'b001;
      checks++;
      if ({p0_gnt, p1_gnt, core_stall} !== exp) begin
        errors++;
        $display("FAIL burst_cycle%0d: got gnt0/gnt1/stall=%b expected %b",
                 i, {p0_gnt, p1_gnt, core_stall}, exp);
      end
      step();
    end
    clear_inputs();
    @(negedge clk);
    checks++;
    if (p0_wait_cnt !== 6'd17) begin
      errors++;
      $display("FAIL burst_wait_cnt: got %0d expected 17", p0_wait_cnt);
    end
  endtask

  task automatic test_gap();
    logic e0, e1;
    do_reset();
    p1_we = 1'b1; p1_lock = 1'b1; p1_addr = 20'h00500; p0_we = 1'b1;
    for (int i = 0; i < 20; i++) begin
      p0_req = (i >= 1);
      p1_req = !(i == 3 || i == 4);
      @(negedge clk);
      e0 = (i == 19);
      e1 = (i <= 2) || (i >= 5 && i <= 17);
      checks++;
      if ({p0_gnt, p1_gnt, core_stall} !== {e0, e1, p0_req & ~e0}) begin
        errors++;
        $display("FAIL gap_cycle%0d: got gnt0/gnt1/stall=%b expected %b",
                 i, {p0_gnt, p1_gnt, core_stall}, {e0, e1, p0_req & ~e0});
      end
      step();
    end
    clear_inputs();
  endtask

  task automatic test_lock_drop();
    logic [1:0] exp;
    do_reset();
    p1_we = 1'b1; p0_we = 1'b1;
    for (int i = 0; i < 4; i++) begin
      p1_req  = 1'b1;
      p1_lock = (i <= 1);
      p0_req  = (i >= 1);
      case (i)
        0:       exp = 2'b01;
        1:       exp = 2'b01;
        2:       exp = 2'b00;
        default: exp = 2'b10;
      endcase
      @(negedge clk);
      checks++;
      if ({p0_gnt, p1_gnt} !== exp) begin
        errors++;
        $display("FAIL lock_drop_cycle%0d: got gnt0/gnt1=%b expected %b",
                 i, {p0_gnt, p1_gnt}, exp);
      end
      step();
    end
    clear_inputs();
  endtask

  task automatic test_reset_midread();
    do_reset();
    p1_req = 1'b1; p1_addr = 20'h00040; mem_rdata = 32'hCAFE_F00D;
    @(negedge clk);
    checks++;
    if ({p1_gnt, mem_re} !== 2'b11) begin
      errors++;
      $display("FAIL midread_grant: got gnt1/re=%b expected 11", {p1_gnt, mem_re});
    end
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if ({p0_gnt, p1_gnt, mem_we, mem_re} !== 4'b0) begin
      errors++;
      $display("FAIL midread_async_gate: got %b expected 0000",
               {p0_gnt, p1_gnt, mem_we, mem_re});
    end
    for (int i = 0; i < 2; i++) begin
      step();
      @(negedge clk);
      checks++;
      if ({p0_rvalid, p1_rvalid, p0_gnt, p1_gnt, mem_we, mem_re} !== 6'b0 ||
          p1_rdata !== 32'h0) begin
        errors++;
        $display("FAIL midread_held%0d: got %b rdata=%h expected 000000 rdata=0",
                 i, {p0_rvalid, p1_rvalid, p0_gnt, p1_gnt, mem_we, mem_re}, p1_rdata);
      end
    end
    step();
    clear_inputs();
    rst = 1'b1;
    p0_req = 1'b1; p0_we = 1'b1; p1_req = 1'b1; p1_we = 1'b1;
    @(negedge clk);
    checks++;
    if ({p0_gnt, p1_gnt} !== 2'b10) begin
      errors++;
      $display("FAIL midread_first_conflict: got gnt0/gnt1=%b expected 10",
               {p0_gnt, p1_gnt});
    end
    step();
    clear_inputs();
    p0_req = 1'b1; p0_addr = 20'h00044;
    @(negedge clk);
    checks++;
    if (p0_gnt !== 1'b1) begin
      errors++;
      $display("FAIL pending_read_grant: got %b expected 1", p0_gnt);
    end
    step();
    clear_inputs();
    mem_rdata = 32'h0BAD_F00D;
    #1;
    checks++;
    if (p0_rvalid !== 1'b1) begin
      errors++;
      $display("FAIL pending_read_rvalid: got %b expected 1", p0_rvalid);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (p0_rvalid !== 1'b0 || p0_rdata !== 32'h0) begin
      errors++;
      $display("FAIL pending_read_dropped: got rv=%b data=%h expected rv=0 data=0",
               p0_rvalid, p0_rdata);
    end
    step();
    rst = 1'b1;
    clear_inputs();
  endtask

  task automatic test_byte_write();
    do_reset();
    p0_req = 1'b1; p0_we = 1'b1; p0_be = 1'b1;
    p0_addr = 20'h00003; p0_wdata = 32'h0000_00AB;
    @(negedge clk);
    checks++;
    if ({mem_we, mem_be, mem_re, p0_gnt} !== 4'b1101) begin
      errors++;
      $display("FAIL byte_write_strobes: got we/be/re/gnt=%b expected 1101",
               {mem_we, mem_be, mem_re, p0_gnt});
    end
    checks++;
    if (mem_addr !== 20'h00003 || mem_wdata !== 32'h0000_00AB) begin
      errors++;
      $display("FAIL byte_write_bus: got addr=%h wdata=%h expected 00003/000000ab",
               mem_addr, mem_wdata);
    end
    step();
    clear_inputs();
    mem_rdata = 32'hFFFF_FFFF;
    @(negedge clk);
    checks++;
    if ({p0_rvalid, p1_rvalid} !== 2'b00) begin
      errors++;
      $display("FAIL byte_write_no_rvalid: got %b expected 00", {p0_rvalid, p1_rvalid});
    end
    clear_inputs();
  endtask

  task automatic test_saturate();
    do_reset();
    p1_req = 1'b1; p1_we = 1'b1; p1_lock = 1'b1;
    step();
    p1_req = 1'b0;
    p0_req = 1'b1; p0_we = 1'b1;
    for (int i = 1; i <= 70; i++) begin
      @(negedge clk);
      if (i == 63) begin
        checks++;
        if (p0_wait_cnt !== 6'd62 || core_stall !== 1'b1) begin
          errors++;
          $display("FAIL saturate_mid: got cnt=%0d stall=%b expected cnt=62 stall=1",
                   p0_wait_cnt, core_stall);
        end
      end
      step();
    end
    clear_inputs();
    @(negedge clk);
    checks++;
    if (p0_wait_cnt !== 6'd63) begin
      errors++;
      $display("FAIL saturate_cap: got %0d expected 63", p0_wait_cnt);
    end
  endtask

  initial begin
    clear_inputs();
    rst = 1'b0;
    test_reset();
    test_p0_read();
    test_alternate();
    test_burst();
    test_gap();
    test_lock_drop();
    test_reset_midread();
    test_byte_write();
    test_saturate();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
